load_store_unit: RTL

Parametrised memory-access stage for the RISC-V core. It sits between execute and writeback and takes one `MemFunc` request at a time (load/store, byte/half/word). It drives a word-wide memory bus with byte lanes, aligns and sign/zero-extends load data, and splits accesses that cross a bus word into two beats. Unlike the fixed single-beat word path, it is generic in bus width and handles boundary-crossing accesses.

---
 rtl/load_store_unit.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage between execute and writeback: formats stores onto byte lanes,
// aligns and extends load data, and splits bus-word-crossing accesses into two beats.
module load_store_unit #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic [3:0]            req_func_in,
    input  logic [ADDR_W-1:0]     req_addr_in,
    input  logic [31:0]           req_data_in,
    input  logic [4:0]            req_dst_in,
    output logic                  mem_valid_out,
    input  logic                  mem_ready_in,
    output logic [ADDR_W-1:0]     mem_addr_out,
    output logic                  mem_we_out,
    output logic [DATA_W/8-1:0]   mem_be_out,
    output logic [DATA_W-1:0]     mem_wdata_out,
    input  logic                  mem_rvalid_in,
    input  logic [DATA_W-1:0]     mem_rdata_in,
    output logic                  resp_valid_out,
    input  logic                  resp_ready_in,
    output logic [31:0]           resp_data_out,
    output logic [4:0]            resp_dst_out,
    output logic                  resp_fault_out
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    localparam logic [3:0] FUNC_LW  = 4'd0;
    localparam logic [3:0] FUNC_LH  = 4'd1;
    localparam logic [3:0] FUNC_LHU = 4'd2;
    localparam logic [3:0] FUNC_LB  = 4'd3;
    localparam logic [3:0] FUNC_LBU = 4'd4;
    localparam logic [3:0] FUNC_SW  = 4'd5;
    localparam logic [3:0] FUNC_SH  = 4'd6;
    localparam logic [3:0] FUNC_SB  = 4'd7;
    localparam logic [3:0] FUNC_NOP = 4'd8;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} lsuStateT;

    lsuStateT                state;
    logic [3:0]              funcReg;
    logic [OFF_W-1:0]        offReg;
    logic                    crossReg;
    logic [ADDR_W-1:0]       baseAddr;
    logic [4:0]              dstReg;
    logic [DATA_W-1:0]       beat0Reg;
    logic [DATA_W-1:0]       wdataHi;
    logic [BYTES-1:0]        beHi;

    logic [OFF_W-1:0]        reqOff;
    logic [ADDR_W-1:0]       reqBase;
    logic                    reqCross;
    logic                    reqStore;
    logic                    reqNop;
    logic                    reqIllegal;
    logic [3:0]              reqSizeMask;
    logic [31:0]             reqMaskedData;
    logic [2*BYTES-1:0]      reqLaneMask;
    logic [2*DATA_W-1:0]     reqLaneData;

    function automatic logic [2:0] sizeBytes(input logic [3:0] func);
        case (func)
            FUNC_LW, FUNC_SW:            sizeBytes = 3'd4;
            FUNC_LH, FUNC_LHU, FUNC_SH:  sizeBytes = 3'd2;
            FUNC_LB, FUNC_LBU, FUNC_SB:  sizeBytes = 3'd1;
            default:                     sizeBytes = 3'd0;
        endcase
    endfunction

    function automatic logic isStoreFunc(input logic [3:0] func);
        isStoreFunc = (func == FUNC_SW) || (func == FUNC_SH) || (func == FUNC_SB);
    endfunction

    // Shift the (one or two) captured bus words down to the access offset, then extend.
    function automatic logic [31:0] formatLoad(input logic [3:0]        func,
                                               input logic [OFF_W-1:0]  off,
                                               input logic [DATA_W-1:0] hi,
                                               input logic [DATA_W-1:0] lo);
        logic [31:0] word;
        word = 32'({hi, lo} >> {off, 3'b000});
        case (func)
            FUNC_LW:  formatLoad = word;
            FUNC_LH:  formatLoad = {{16{word[15]}}, word[15:0]};
            FUNC_LHU: formatLoad = {16'h0000, word[15:0]};
            FUNC_LB:  formatLoad = {{24{word[7]}}, word[7:0]};
            FUNC_LBU: formatLoad = {24'h000000, word[7:0]};
            default:  formatLoad = 32'h0;
        endcase
    endfunction

    // Decode the incoming request; only sampled when it is accepted in IDLE.
    always_comb begin
        reqOff        = req_addr_in[OFF_W-1:0];
        reqBase       = {req_addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        reqCross      = (5'(reqOff) + 5'(sizeBytes(req_func_in))) > 5'(BYTES);
        reqStore      = isStoreFunc(req_func_in);
        reqNop        = (req_func_in == FUNC_NOP);
        reqIllegal    = (req_func_in > FUNC_NOP);
        reqSizeMask   = (sizeBytes(req_func_in) == 3'd4) ? 4'b1111 :
                        (sizeBytes(req_func_in) == 3'd2) ? 4'b0011 :
                        (sizeBytes(req_func_in) == 3'd1) ? 4'b0001 : 4'b0000;
        reqMaskedData = req_data_in & {{8{reqSizeMask[3]}}, {8{reqSizeMask[2]}},
                                       {8{reqSizeMask[1]}}, {8{reqSizeMask[0]}}};
        reqLaneMask   = {{(2*BYTES-4){1'b0}}, reqSizeMask} << reqOff;
        reqLaneData   = {{(2*DATA_W-32){1'b0}}, reqMaskedData} << {reqOff, 3'b000};
    end

    assign req_ready_out = (state == IDLE);

    // Transaction FSM; every bus and response output is registered here.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            funcReg        <= 4'h0;
            offReg         <= '0;
            crossReg       <= 1'b0;
            baseAddr       <= '0;
            dstReg         <= 5'd0;
            beat0Reg       <= '0;
            wdataHi        <= '0;
            beHi           <= '0;
            mem_valid_out  <= 1'b0;
            mem_addr_out   <= '0;
            mem_we_out     <= 1'b0;
            mem_be_out     <= '0;
            mem_wdata_out  <= '0;
            resp_valid_out <= 1'b0;
            resp_data_out  <= 32'h0;
            resp_dst_out   <= 5'd0;
            resp_fault_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_in) begin
                        funcReg  <= req_func_in;
                        offReg   <= reqOff;
                        crossReg <= reqCross;
                        baseAddr <= reqBase;
                        dstReg   <= req_dst_in;
                        beat0Reg <= '0;
                        wdataHi  <= reqStore ? reqLaneData[2*DATA_W-1:DATA_W] : '0;
                        beHi     <= reqLaneMask[2*BYTES-1:BYTES];
                        if (reqNop || reqIllegal || (reqCross && !SPLIT_MISALIGNED)) begin
                            state          <= RESP;
                            resp_valid_out <= 1'b1;
                            resp_data_out  <= 32'h0;
                            resp_dst_out   <= req_dst_in;
                            resp_fault_out <= !reqNop;
                        end else begin
                            state         <= REQ0;
                            mem_valid_out <= 1'b1;
                            mem_addr_out  <= reqBase;
                            mem_we_out    <= reqStore;
                            mem_be_out    <= reqLaneMask[BYTES-1:0];
                            mem_wdata_out <= reqStore ? reqLaneData[DATA_W-1:0] : '0;
                        end
                    end
                end
                REQ0: begin
                    if (mem_ready_in) begin
                        if (isStoreFunc(funcReg) && crossReg) begin
                            state         <= REQ1;
                            mem_addr_out  <= baseAddr + ADDR_W'(BYTES);
                            mem_be_out    <= beHi;
                            mem_wdata_out <= wdataHi;
                        end else begin
                            mem_valid_out <= 1'b0;
                            mem_addr_out  <= '0;
                            mem_we_out    <= 1'b0;
                            mem_be_out    <= '0;
                            mem_wdata_out <= '0;
                            if (isStoreFunc(funcReg)) begin
                                state          <= RESP;
                                resp_valid_out <= 1'b1;
                                resp_data_out  <= 32'h0;
                                resp_dst_out   <= dstReg;
                                resp_fault_out <= 1'b0;
                            end else begin
                                state <= WAIT0;
                            end
                        end
                    end
                end
                WAIT0: begin
                    if (mem_rvalid_in) begin
                        beat0Reg <= mem_rdata_in;
                        if (crossReg) begin
                            state         <= REQ1;
                            mem_valid_out <= 1'b1;
                            mem_addr_out  <= baseAddr + ADDR_W'(BYTES);
                            mem_we_out    <= 1'b0;
                            mem_be_out    <= beHi;
                            mem_wdata_out <= '0;
                        end else begin
                            state          <= RESP;
                            resp_valid_out <= 1'b1;
                            resp_data_out  <= formatLoad(funcReg, offReg, '0, mem_rdata_in);
                            resp_dst_out   <= dstReg;
                            resp_fault_out <= 1'b0;
                        end
                    end
                end
                REQ1: begin
                    if (mem_ready_in) begin
                        mem_valid_out <= 1'b0;
                        mem_addr_out  <= '0;
                        mem_we_out    <= 1'b0;
                        mem_be_out    <= '0;
                        mem_wdata_out <= '0;
                        if (isStoreFunc(funcReg)) begin
                            state          <= RESP;
                            resp_valid_out <= 1'b1;
                            resp_data_out  <= 32'h0;
                            resp_dst_out   <= dstReg;
                            resp_fault_out <= 1'b0;
                        end else begin
                            state <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (mem_rvalid_in) begin
                        state          <= RESP;
                        resp_valid_out <= 1'b1;
                        resp_data_out  <= formatLoad(funcReg, offReg, mem_rdata_in, beat0Reg);
                        resp_dst_out   <= dstReg;
                        resp_fault_out <= 1'b0;
                    end
                end
                RESP: begin
                    if (resp_ready_in) begin
                        state          <= IDLE;
                        resp_valid_out <= 1'b0;
                        resp_data_out  <= 32'h0;
                        resp_dst_out   <= 5'd0;
                        resp_fault_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
